// File: rtl/mvm_wb_sequencer.sv
// rtl/mvm_wb_sequencer.sv - Wishbone slave sequencer for the matrix_vector_mul_core datapath
// Define MVM_SEQ_IRQ_EN to add the irq_o output and the CTRL.IRQ_EN bit.
module mvm_wb_sequencer #(
    parameter int ROWS         = 4,
    parameter int COLUMNS      = 4,
    parameter int WIDTH        = 8,
    parameter int CORE_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    output logic [ROWS*COLUMNS*WIDTH-1:0] core_x1_o,
    output logic [COLUMNS*WIDTH-1:0]      core_x2_o,
    output logic                          core_clk_enable_o,
`ifdef MVM_SEQ_IRQ_EN
    output logic                          irq_o,
`endif
    input  logic [ROWS*WIDTH-1:0]         core_y_i
);
    localparam int MW = ROWS*COLUMNS*WIDTH/32;
    localparam int VW = COLUMNS*WIDTH/32;
    localparam int RW = ROWS*WIDTH/32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic [MW-1:0][31:0]   r_mat;
    logic [VW-1:0][31:0]   r_vec;
    logic [RW-1:0][31:0]   r_res;
    logic                  r_done, r_err;
    logic                  w_done_nxt, w_err_nxt;
    logic                  w_access, w_wr, w_start, w_clr, w_start_ok, w_busy;
    logic                  w_mat_hit, w_vec_hit, w_op_wr, w_irq_en_rd;
    logic [5:0]            w_word;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_unused   = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};
    assign w_word     = wbs_adr_i[7:2];
    // A new access is only taken while ack is low, giving the 2-cycle handshake.
    assign w_access   = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr       = w_access & wbs_we_i;
    assign w_start    = w_wr & (w_word == 6'd0) & wbs_dat_i[0];
    assign w_clr      = w_wr & (w_word == 6'd0) & wbs_dat_i[1];
    assign w_start_ok = w_start & ~w_busy;
    assign w_mat_hit  = (int'(w_word) >= 4) && (int'(w_word) < 4 + MW);
    assign w_vec_hit  = (int'(w_word) >= 8) && (int'(w_word) < 8 + VW);
    assign w_op_wr    = w_wr & (w_mat_hit | w_vec_hit);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:     if (r_cnt == 4'd0) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = w_start_ok ? S_RUN : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy            = (r_state == S_RUN) || (r_state == S_CAPTURE);
        core_clk_enable_o = (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                 r_cnt <= 4'd0;
        else if (w_start_ok)       r_cnt <= 4'(CORE_LATENCY - 1);
        else if (r_state == S_RUN) r_cnt <= r_cnt - 4'd1;
    end

    // CLR is applied before START and before any new error in the same access.
    always_comb begin
        w_done_nxt = r_done;
        w_err_nxt  = r_err;
        if (w_clr) begin
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b0;
        end
        if (r_state == S_DONE) w_done_nxt = 1'b1;
        if (w_start_ok)        w_done_nxt = 1'b0;
        if ((w_start | w_op_wr) & w_busy) w_err_nxt = 1'b1;
    end

`ifdef MVM_SEQ_IRQ_EN
    logic r_irq_en, r_irq, w_irq_en_nxt;
    assign w_irq_en_nxt = (w_wr && w_word == 6'd0) ? wbs_dat_i[2] : r_irq_en;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_done_nxt & w_irq_en_nxt;
        end
    end
    assign irq_o       = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_word == 6'd0)      w_rdata = {29'd0, w_irq_en_rd, 2'b00};
        else if (w_word == 6'd1) w_rdata = {24'd0, 2'b00, r_state, 1'b0, r_err, r_done, w_busy};
        for (int k = 0; k < MW; k++) if (int'(w_word) == 4 + k)  w_rdata = r_mat[k];
        for (int k = 0; k < VW; k++) if (int'(w_word) == 8 + k)  w_rdata = r_vec[k];
        for (int k = 0; k < RW; k++) if (int'(w_word) == 12 + k) w_rdata = r_res[k];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= (w_access & ~wbs_we_i) ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mat  <= '0;
            r_vec  <= '0;
            r_res  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (r_state == S_CAPTURE) r_res <= core_y_i;
            if (w_wr && !w_busy) begin
                for (int k = 0; k < MW; k++)
                    for (int b = 0; b < 4; b++)
                        if (int'(w_word) == 4 + k && wbs_sel_i[b])
                            r_mat[k][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                for (int k = 0; k < VW; k++)
                    for (int b = 0; b < 4; b++)
                        if (int'(w_word) == 8 + k && wbs_sel_i[b])
                            r_vec[k][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign core_x1_o = r_mat;
    assign core_x2_o = r_vec;
endmodule

// File: tb/tb_mvm_wb_sequencer.sv
// tb/tb_mvm_wb_sequencer.sv - scoreboard bench for mvm_wb_sequencer with a matrix-vector core model
`timescale 1ns/1ps
module tb_mvm_wb_sequencer;
    logic         clk = 1'b0;
    logic         rstn, stb, cyc, we;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_i, dat_o;
    logic         ack, en;
    logic [127:0] x1;
    logic [31:0]  x2, y;
`ifdef MVM_SEQ_IRQ_EN
    logic         irq;
`endif

    always #5 clk = ~clk;

    mvm_wb_sequencer dut (
        .clk(clk), .rstn(rstn), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack),
        .wbs_dat_o(dat_o), .core_x1_o(x1), .core_x2_o(x2), .core_clk_enable_o(en),
`ifdef MVM_SEQ_IRQ_EN
        .irq_o(irq),
`endif
        .core_y_i(y)
    );

    localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_MAT = 32'h10;
    localparam logic [31:0] A_VEC = 32'h20, A_RES = 32'h30;

    // y[r] = sum_c x1[r][c] * x2[c], modulo 2^8; element (r,c) lives in byte c of word r
    function automatic logic [31:0] mvm(input logic [127:0] m, input logic [31:0] v);
        logic [31:0] r, acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int c = 0; c < 4; c++)
                acc = acc + 32'(m[32*i + 8*c +: 8]) * 32'(v[8*c +: 8]);
            r[8*i +: 8] = acc[7:0];
        end
        return r;
    endfunction

    // Core stand-in: two clock-enabled pipeline stages
    logic [31:0] p1 = '0, p2 = '0;
    always @(posedge clk) if (en) begin
        p1 <= mvm(x1, x2);
        p2 <= p1;
    end
    assign y = p2;

    int n_pass = 0, n_total = 0, en_cnt = 0;
    logic [31:0] m_mat [4];
    logic [31:0] m_vec, m_res;

    typedef struct { bit rd; logic [31:0] exp; string name; } exp_t;
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) if (en === 1'b1) en_cnt++;

    always @(negedge clk) begin
        if (rstn === 1'b1 && ack === 1'b1) begin
            exp_t x;
            check("sb_pending_on_ack", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.rd) check(x.name, dat_o, x.exp);
            end
        end
    end

    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e, input string nm);
        exp_t x;
        int   lat;
        @(negedge clk);
        x.rd = !w; x.exp = e; x.name = nm;
        sb.push_back(x);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack !== 1'b1 && lat < 8);
        stb = 1'b0; cyc = 1'b0;
        check({nm, "_ack_latency"}, 32'(lat), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 4'hF, '0, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        bus(1'b0, a, 32'h0, 4'hF, e, nm);
    endtask

    // k<4: matrix word k, k==4: vector word
    task automatic wr_op(input int k, input logic [31:0] d, input logic [3:0] s, input bit drop);
        bus(1'b1, (k < 4) ? A_MAT + 32'(4*k) : A_VEC, d, s, '0, "op_wr");
        if (!drop)
            for (int b = 0; b < 4; b++)
                if (s[b]) begin
                    if (k < 4) m_mat[k][8*b +: 8] = d[8*b +: 8];
                    else       m_vec[8*b +: 8]    = d[8*b +: 8];
                end
    endtask

    function automatic logic [31:0] model_res();
        return mvm({m_mat[3], m_mat[2], m_mat[1], m_mat[0]}, m_vec);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_mat[k] = '0;
        m_vec = '0;
        m_res = '0;
    endtask

    initial begin
        logic [31:0] e;
        int          ri;
        rstn = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_clk_enable", 32'(en), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat_o", dat_o, 32'd0);
        rstn = 1'b1;
        rd(A_STAT, 32'h0, "reset_status");
        rd(A_RES, 32'h0, "reset_result");
        rd(A_MAT, 32'h0, "reset_matrix0");

        for (int k = 0; k < 4; k++) wr_op(k, 32'h01010101, 4'hF, 1'b0);
        wr_op(4, 32'h04030201, 4'hF, 1'b0);
        e = model_res();
        en_cnt = 0;
        wr(A_CTRL, 32'h1);
        repeat (1) @(negedge clk);
        rd(A_STAT, 32'h21, "status_in_capture");
        rd(A_STAT, 32'h02, "status_done");
        check("enable_cycles", 32'(en_cnt), 32'd2);
        rd(A_RES, e, "result_directed");
        check("result_directed_value", e, 32'h0A0A0A0A);
        m_res = e;

        wr_op(4, 32'hFFFFFFFF, 4'b0010, 1'b0);
        rd(A_VEC, 32'h0403FF01, "vector_byte_enable");

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 5; k++) wr_op(k, $urandom, 4'($urandom_range(1, 15)), 1'b0);
            ri = $urandom_range(0, 3);
            rd(A_MAT + 32'(4*ri), m_mat[ri], "rand_matrix_readback");
            rd(A_VEC, m_vec, "rand_vector_readback");
            e = model_res();
            en_cnt = 0;
            wr(A_CTRL, ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1);
            repeat (1) @(negedge clk);
            rd(A_RES, m_res, "result_old_during_capture");
            rd(A_STAT, 32'h02, "rand_status_done");
            check("rand_enable_cycles", 32'(en_cnt), 32'd2);
            rd(A_RES, e, "rand_result");
            m_res = e;
        end

        en_cnt = 0;
        e = model_res();
        wr(A_CTRL, 32'h1);
        wr_op(1, ~m_mat[1], 4'hF, 1'b1);
        rd(A_STAT, 32'h34, "busy_write_status_done_state");
        rd(A_STAT, 32'h06, "busy_write_status_err");
        check("busy_write_enable_cycles", 32'(en_cnt), 32'd2);
        rd(A_MAT + 32'h4, m_mat[1], "busy_write_dropped");
        rd(A_RES, e, "busy_write_run_result");
        m_res = e;
        wr(A_CTRL, 32'h2);
        rd(A_STAT, 32'h00, "clr_status");

        wr(A_CTRL, 32'h1);
        wr(A_CTRL, 32'h1);
        rd(A_STAT, 32'h34, "busy_start_status_done_state");
        rd(A_STAT, 32'h06, "busy_start_status_err");
        wr(A_CTRL, 32'h3);
        rd(A_STAT, 32'h11, "clr_start_status_run");
        rd(A_STAT, 32'h30, "clr_start_status_done_state");
        rd(A_STAT, 32'h02, "clr_start_status_done");

        wr(A_STAT, 32'hFF);
        rd(A_STAT, 32'h02, "status_write_ignored");
        wr(32'h40, $urandom);
        rd(32'h40, 32'h0, "unmapped_read");
        rd(32'h08, 32'h0, "unmapped_read_gap");
        rd(A_CTRL, 32'h0, "ctrl_read");
        rd(32'hABCD_0010, m_mat[0], "address_alias");

`ifdef MVM_SEQ_IRQ_EN
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, 32'h4, "irq_en_readback");
        wr(A_CTRL, 32'h5);
        repeat (4) @(negedge clk);
        check("irq_with_done", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h6);
        check("irq_cleared", 32'(irq), 32'd0);
`endif

        wr(A_CTRL, 32'h1);
        @(negedge clk);
        check("enable_in_run", 32'(en), 32'd1);
        rstn = 1'b0;
        #1;
        check("enable_async_reset", 32'(en), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd(A_STAT, 32'h0, "midrun_reset_status");
        rd(A_RES, m_res, "midrun_reset_result");
        rd(A_MAT, m_mat[0], "midrun_reset_matrix0");
        rd(A_VEC, m_vec, "midrun_reset_vector");

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_total);
        $fatal(1);
    end
endmodule

// File: doc/mvm_wb_sequencer.md
Name: mvm_wb_sequencer

Overview:
- Wishbone-slave controller that owns the matrix_vector_mul_core datapath.
- Holds matrix (x1) and vector (x2) staging registers written over the 32-bit Wishbone bus.
- On a software start, drives clk_enable for the core's pipeline latency, captures y into a result register and reports busy/done/error status.
- Sits between the Wishbone slave port and the core, replacing direct bus-to-core wiring.

Parameters:
- ROWS, 4, matrix rows / result elements
- COLUMNS, 4, matrix columns / vector elements
- WIDTH, 8, bits per element (x1, x2 and y)
- CORE_LATENCY, 2, clk cycles from operands stable with clk_enable=1 to valid y (legal range 1..15)
- Constraint: ROWS*COLUMNS*WIDTH, COLUMNS*WIDTH and ROWS*WIDTH are multiples of 32.
  - Defaults give MW=4 matrix words, VW=1 vector word, RW=1 result word.

Ports:
- clk  in  1  single clock for bus and core
- rstn  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address; bits [7:2] decoded, others ignored
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data
- core_x1_o  out  ROWS*COLUMNS*WIDTH  matrix to core; word k at bits [32k+31:32k]
- core_x2_o  out  COLUMNS*WIDTH  vector to core
- core_clk_enable_o  out  1  core clock enable
- core_y_i  in  ROWS*WIDTH  core result

Behaviour:
- Reset (async, rstn=0):
  - All staging/result regs 0.
  - FSM=IDLE.
  - wbs_ack_o=0, wbs_dat_o=0, core_clk_enable_o=0.
  - Status bits 0.
- Bus timing:
  - wbs_ack_o rises the cycle after stb&cyc while ack=0, for exactly one cycle, then drops.
  - Back-to-back accesses therefore complete every 2 cycles.
  - Writes and reads take effect/sample on the ack-asserting edge.
  - wbs_dat_o is valid with ack and 0 otherwise.
- Address map (word offset = adr[7:2]):
  - 0x00 CTRL W: bit0=START (write-1 pulse, reads 0); bit1=CLR (clears done and err); bit2=IRQ_EN (see option).
  - 0x04 STATUS R: bit0=busy, bit1=done, bit2=err, bits[7:4]=FSM state code. Writes are ignored.
  - 0x10+4k, k<MW: matrix word k, RW.
  - 0x20+4k, k<VW: vector word k, RW.
  - 0x30+4k, k<RW: result word k, RO.
  - Unmapped: reads return 0, writes are dropped, ack still given.
- Byte enables: honoured on operand writes; unselected bytes are unchanged.
- Operand outputs: core_x1_o/core_x2_o continuously drive the staging registers.
- FSM:
  - IDLE:
    - START=1 -> RUN, counter=CORE_LATENCY-1, done=0.
  - RUN:
    - core_clk_enable_o=1, busy=1.
    - Counter decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE:
    - Result reg <= core_y_i, core_clk_enable_o=0, busy=1 -> DONE.
  - DONE:
    - done=1, busy=0 -> IDLE in the same cycle; done stays set until CLR or the next START.
- Start-to-done latency: CORE_LATENCY+2 cycles after the START write ack edge.
- Error cases (err is sticky, cleared only by CLR or reset):
  - Operand write while busy=1: data dropped, err=1.
  - START while busy=1: ignored, err=1.
- Simultaneous events:
  - START and CLR in the same write: CLR is applied first, then START.
  - Result read during CAPTURE returns the old result value.
- Reset mid-operation: returns to IDLE immediately; clk_enable drops asynchronously.
- No combinational path from Wishbone inputs to any output.

Optional Feature:
- Macro: MVM_SEQ_IRQ_EN.
- When defined:
  - Adds output port irq_o (1 bit), registered, reset 0.
  - irq_o = done & IRQ_EN (level); it clears with CLR or a new START.
  - IRQ_EN reads back at CTRL bit2.
- When undefined:
  - No irq_o port.
  - CTRL bit2 is a write-ignored, read-0 bit.
  - All other behaviour is identical.

Test Plan:
- Reset, then read STATUS, result word 0 and matrix word 0 -> all 0x00000000; core_clk_enable_o=0; ack one cycle after stb.
- Write matrix words 0x01010101 x4, vector 0x04030201, START -> clk_enable high exactly 2 cycles; done=1 after 4 cycles; STATUS=0x2.
- Same sequence; read result -> equals core_y_i at capture (bench model: per-row element sums, 0x0A0A0A0A).
- Write vector with sel=4'b0010, data 0xFFFFFFFF, over 0x04030201 -> reads 0x0403FF01.
- During RUN, write matrix word 1 and issue START -> word unchanged, err=1, run completes normally; CLR -> STATUS=0x0.
- Assert rstn=0 mid-RUN -> clk_enable=0 immediately, STATUS=0 after release; with MVM_SEQ_IRQ_EN and IRQ_EN=1, irq_o rises with done and falls on CLR.
